// File: rtl/alsu_mc.sv
// rtl/alsu_mc.sv - parametrised multi-cycle ALSU with valid/ready input and shift-add multiplier
module alsu_mc #(
  parameter int    WIDTH          = 8,
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON",
  parameter int    LED_W          = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [2:0]         opcode,
  input  logic               cin,
  input  logic               serial_in,
  input  logic               red_op_A,
  input  logic               red_op_B,
  input  logic               bypass_A,
  input  logic               bypass_B,
  input  logic               direction,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] out,
  output logic [LED_W-1:0]   leds
);

  localparam int OW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  // Resolved parameter choices; an unrecognised value makes the affected result hold.
  localparam bit PRI_A  = (INPUT_PRIORITY == "A");
  localparam bit PRI_OK = PRI_A || (INPUT_PRIORITY == "B");
  localparam bit FA_ON  = (FULL_ADDER == "ON");
  localparam bit FA_OK  = FA_ON || (FULL_ADDER == "OFF");

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t            state_q, state_d;
  logic [OW-1:0]     out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic [LED_W-1:0]  leds_q, leds_d;
  logic [OW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [OW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [WIDTH:0]    sum;
  logic [WIDTH-1:0]  red_x;
  logic [WIDTH-1:0]  byp_x;
  logic [OW-1:0]     acc_next;
  logic              red_any;

  assign sum      = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cin & FA_ON};
  assign red_x    = (red_op_A && (!red_op_B || PRI_A)) ? A : B;
  assign byp_x    = (bypass_A && (!bypass_B || PRI_A)) ? A : B;
  assign red_any  = red_op_A | red_op_B;
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign leds      = leds_q;

  // State and datapath registers; reset also abandons any multiply in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      leds_q      <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      leds_q      <= leds_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next state: evaluate an accepted request (bypass > invalid > opcode) or step the multiplier.
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    leds_d      = leds_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          out_valid_d = 1'b1;
          if (bypass_A || bypass_B) begin
            if (!(bypass_A && bypass_B && !PRI_OK)) begin
              out_d  = {{WIDTH{1'b0}}, byp_x};
              leds_d = '0;
            end
          end else if (opcode[2:1] == 2'b11 ||
                       (red_any && opcode inside {[3'b010:3'b101]})) begin
            out_d  = '0;
            leds_d = ~leds_q;
          end else begin
            case (opcode)
              3'b000, 3'b001: begin
                if (red_any) begin
                  if (!(red_op_A && red_op_B && !PRI_OK)) begin
                    out_d  = {{(OW-1){1'b0}}, opcode[0] ? ^red_x : &red_x};
                    leds_d = '0;
                  end
                end else begin
                  out_d  = {{WIDTH{1'b0}}, opcode[0] ? (A ^ B) : (A & B)};
                  leds_d = '0;
                end
              end
              3'b010: begin
                if (FA_OK) begin
                  out_d  = {{(WIDTH-1){1'b0}}, sum};
                  leds_d = '0;
                end
              end
              3'b011: begin
                out_valid_d = 1'b0;
                state_d     = S_MUL;
                mcand_d     = {{WIDTH{1'b0}}, A};
                mplier_d    = B;
                acc_d       = '0;
                cnt_d       = '0;
              end
              3'b100: begin
                out_d  = direction ? {out_q[OW-2:0], serial_in}
                                   : {serial_in, out_q[OW-1:1]};
                leds_d = '0;
              end
              3'b101: begin
                out_d  = direction ? {out_q[OW-2:0], out_q[OW-1]}
                                   : {out_q[0], out_q[OW-1:1]};
                leds_d = '0;
              end
              default: ;
            endcase
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_next;
        mcand_d  = {mcand_q[OW-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          out_d       = acc_next;
          out_valid_d = 1'b1;
          leds_d      = '0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
